vga_port_ctl: RTL and testbench

- CPU-side I/O responder for the video subsystem; the writer end of the state the scan-out engine reads.
- Decodes CPU port strobes into:
  - writes into the palette DAC RAM (12-bit RGB entries);
  - palette readback through the DAC RAM second port;
  - CRTC cursor registers that drive the scan-out cursor position;
  - the video mode/page register;
  - the vertical-retrace status port.
- Sits between the CPU I/O bus and the video output block.

---
 rtl/vga_port_if.sv | 12 +
 rtl/vga_port_ctl.sv | 166 ++++++++++++++++
 tb/tb_vga_port_ctl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_port_if.sv
// CPU I/O port bus between the host and the video port responder.
// Master drives address, strobes and write data; slave returns registered read data.
interface vga_port_if;
  logic [15:0] port_a;
  logic        port_w;
  logic        port_r;
  logic [7:0]  port_i;
  logic [7:0]  port_o;

  modport master (output port_a, port_w, port_r, port_i, input port_o);
  modport slave  (input port_a, port_w, port_r, port_i, output port_o);
endinterface

// File: rtl/vga_port_ctl.sv
// CPU port responder for palette DAC, CRTC cursor, mode/page and retrace status.
// Read data lands in port_o one cycle after the strobe; no backpressure, one access per strobe.
module vga_port_ctl #(
  parameter logic [11:0] CURSOR_RST = 12'h000,
  parameter logic [1:0]  MODE_RST   = 2'b00
) (
  input  logic        clock,
  input  logic        reset,
  vga_port_if.slave   bus,
  output logic        dac_we,
  output logic [7:0]  dac_wa,
  output logic [11:0] dac_wd,
  output logic [7:0]  dac_ra,
  input  logic [11:0] dac_rq,
  input  logic        vretrace,
  output logic        videomode,
  output logic        page,
  output logic [11:0] cursor
);

  localparam logic [15:0] A_DAC_RD  = 16'h03C7;
  localparam logic [15:0] A_DAC_WR  = 16'h03C8;
  localparam logic [15:0] A_DAC_DAT = 16'h03C9;
  localparam logic [15:0] A_CRTC_IX = 16'h03D4;
  localparam logic [15:0] A_CRTC_DT = 16'h03D5;
  localparam logic [15:0] A_MODE    = 16'h03D8;
  localparam logic [15:0] A_STATUS  = 16'h03DA;

  logic [7:0]  r_port_o;
  logic        r_dac_we;
  logic [7:0]  r_dac_wa;
  logic [11:0] r_dac_wd;
  logic [7:0]  r_wr_idx;
  logic [7:0]  r_rd_idx;
  logic [1:0]  r_wcomp;
  logic [1:0]  r_rcomp;
  logic [3:0]  r_rl;
  logic [3:0]  r_gl;
  logic [1:0]  r_dac_state;
  logic [7:0]  r_crtc_idx;
  logic [11:0] r_cursor;
  logic [1:0]  r_mode;
  logic        r_rf;

  logic        w_wr;
  logic        w_rd;
  logic [3:0]  w_nib;
  logic [7:0]  w_rdata;

  // A write strobe shadows a simultaneous read.
  assign w_wr = bus.port_w;
  assign w_rd = bus.port_r & ~bus.port_w;

  always_comb begin
    w_nib = dac_rq[3:0];
    case (r_rcomp)
      2'd0:    w_nib = dac_rq[11:8];
      2'd1:    w_nib = dac_rq[7:4];
      default: w_nib = dac_rq[3:0];
    endcase
  end

  always_comb begin
    w_rdata = 8'hFF;
    case (bus.port_a)
      A_DAC_RD:  w_rdata = {6'b0, r_dac_state};
      A_DAC_WR:  w_rdata = r_wr_idx;
      A_DAC_DAT: w_rdata = {2'b00, w_nib, w_nib[3:2]};
      A_CRTC_IX: w_rdata = r_crtc_idx;
      A_CRTC_DT: begin
        if (r_crtc_idx == 8'h0E)      w_rdata = {4'b0, r_cursor[11:8]};
        else if (r_crtc_idx == 8'h0F) w_rdata = r_cursor[7:0];
        else                          w_rdata = 8'h00;
      end
      A_MODE:    w_rdata = {6'b0, r_mode};
      A_STATUS:  w_rdata = {4'b0, r_rf, 2'b0, r_rf};
      default:   w_rdata = 8'hFF;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_port_o    <= 8'h00;
      r_dac_we    <= 1'b0;
      r_dac_wa    <= 8'h00;
      r_dac_wd    <= 12'h000;
      r_wr_idx    <= 8'h00;
      r_rd_idx    <= 8'h00;
      r_wcomp     <= 2'd0;
      r_rcomp     <= 2'd0;
      r_rl        <= 4'h0;
      r_gl        <= 4'h0;
      r_dac_state <= 2'd0;
      r_crtc_idx  <= 8'h00;
      r_cursor    <= CURSOR_RST;
      r_mode      <= MODE_RST;
      r_rf        <= 1'b0;
    end else begin
      r_dac_we <= 1'b0;
      if (w_wr) begin
        case (bus.port_a)
          A_DAC_WR: begin
            r_wr_idx    <= bus.port_i;
            r_wcomp     <= 2'd0;
            r_dac_state <= 2'd0;
          end
          A_DAC_DAT: begin
            case (r_wcomp)
              2'd0: begin
                r_rl    <= bus.port_i[5:2];
                r_wcomp <= 2'd1;
              end
              2'd1: begin
                r_gl    <= bus.port_i[5:2];
                r_wcomp <= 2'd2;
              end
              default: begin
                r_dac_we <= 1'b1;
                r_dac_wa <= r_wr_idx;
                r_dac_wd <= {r_rl, r_gl, bus.port_i[5:2]};
                r_wr_idx <= r_wr_idx + 8'd1;
                r_wcomp  <= 2'd0;
              end
            endcase
          end
          A_DAC_RD: begin
            r_rd_idx    <= bus.port_i;
            r_rcomp     <= 2'd0;
            r_dac_state <= 2'd3;
          end
          A_CRTC_IX: r_crtc_idx <= bus.port_i;
          A_CRTC_DT: begin
            if (r_crtc_idx == 8'h0E)      r_cursor[11:8] <= bus.port_i[3:0];
            else if (r_crtc_idx == 8'h0F) r_cursor[7:0]  <= bus.port_i;
          end
          A_MODE:  r_mode <= bus.port_i[1:0];
          default: ;
        endcase
      end
      if (w_rd) begin
        r_port_o <= w_rdata;
        if (bus.port_a == A_DAC_DAT) begin
          if (r_rcomp == 2'd2) begin
            r_rcomp  <= 2'd0;
            r_rd_idx <= r_rd_idx + 8'd1;
          end else begin
            r_rcomp <= r_rcomp + 2'd1;
          end
        end
      end
      // A retrace pulse arriving with a status read leaves the flag set.
      if (vretrace)                              r_rf <= 1'b1;
      else if (w_rd && bus.port_a == A_STATUS)   r_rf <= 1'b0;
    end
  end

  assign bus.port_o = r_port_o;
  assign dac_we     = r_dac_we;
  assign dac_wa     = r_dac_wa;
  assign dac_wd     = r_dac_wd;
  assign dac_ra     = r_rd_idx;
  assign videomode  = r_mode[0];
  assign page       = r_mode[1];
  assign cursor     = r_cursor;

endmodule

// File: tb/tb_vga_port_ctl.sv
// Scoreboard bench for vga_port_ctl: a port-level reference model queues expected reads and
// palette writes; a monitor compares them as the DUT produces read data and dac_we pulses.
module tb_vga_port_ctl;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dac_we;
  logic [7:0]  dac_wa;
  logic [11:0] dac_wd;
  logic [7:0]  dac_ra;
  logic [11:0] dac_rq;
  logic        vretrace;
  logic        videomode;
  logic        page;
  logic [11:0] cursor;

  vga_port_if bus ();

  vga_port_ctl #(.CURSOR_RST(12'h000), .MODE_RST(2'b00)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .dac_we(dac_we), .dac_wa(dac_wa), .dac_wd(dac_wd), .dac_ra(dac_ra), .dac_rq(dac_rq),
    .vretrace(vretrace), .videomode(videomode), .page(page), .cursor(cursor)
  );

  always #5 clock = ~clock;

  // Palette RAM: synchronous second read port, written by the DUT.
  logic [11:0] pal [256];
  always @(posedge clock) begin
    dac_rq <= pal[dac_ra];
    if (dac_we) pal[dac_wa] = dac_wd;
  end

  // Reference model state
  logic [11:0] m_pal [256];
  logic [7:0]  m_wr_idx, m_rd_idx, m_crtc;
  int          m_wcomp, m_rcomp;
  logic [3:0]  m_trip [3];
  logic [1:0]  m_state, m_mode;
  logic [11:0] m_cursor;
  logic        m_rf;

  logic [7:0]  rq [$];
  logic [19:0] dq [$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    m_wr_idx = 0; m_rd_idx = 0; m_crtc = 0; m_wcomp = 0; m_rcomp = 0;
    m_state = 0; m_mode = 2'b00; m_cursor = 12'h000; m_rf = 0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    case (a)
      16'h03C8: begin m_wr_idx = d; m_wcomp = 0; m_state = 0; end
      16'h03C9: begin
        m_trip[m_wcomp] = d[5:2];
        if (m_wcomp == 2) begin
          dq.push_back({m_wr_idx, m_trip[0], m_trip[1], m_trip[2]});
          m_pal[m_wr_idx] = {m_trip[0], m_trip[1], m_trip[2]};
          m_wr_idx = m_wr_idx + 8'd1;
          m_wcomp = 0;
        end else m_wcomp++;
      end
      16'h03C7: begin m_rd_idx = d; m_rcomp = 0; m_state = 2'd3; end
      16'h03D4: m_crtc = d;
      16'h03D5: begin
        if (m_crtc == 8'h0E) m_cursor[11:8] = d[3:0];
        if (m_crtc == 8'h0F) m_cursor[7:0] = d;
      end
      16'h03D8: m_mode = d[1:0];
      default: ;
    endcase
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] a);
    logic [11:0] e;
    logic [3:0]  c;
    case (a)
      16'h03C7: return {6'b0, m_state};
      16'h03C8: return m_wr_idx;
      16'h03C9: begin
        e = m_pal[m_rd_idx];
        c = (m_rcomp == 0) ? e[11:8] : (m_rcomp == 1) ? e[7:4] : e[3:0];
        m_rcomp = (m_rcomp + 1) % 3;
        if (m_rcomp == 0) m_rd_idx = m_rd_idx + 8'd1;
        return {2'b00, c, c[3:2]};
      end
      16'h03D4: return m_crtc;
      16'h03D5: return (m_crtc == 8'h0E) ? {4'b0, m_cursor[11:8]} :
                       (m_crtc == 8'h0F) ? m_cursor[7:0] : 8'h00;
      16'h03D8: return {6'b0, m_mode};
      16'h03DA: begin
        c = {m_rf, 2'b00, m_rf};
        m_rf = 1'b0;
        return {4'b0, c};
      end
      default:  return 8'hFF;
    endcase
  endfunction

  // kind: 0 write, 1 read, 2 write+read together
  task automatic access(input int kind, input logic [15:0] a, input logic [7:0] d, input bit vr);
    @(negedge clock);
    bus.port_a = a; bus.port_i = d;
    bus.port_w = (kind != 1); bus.port_r = (kind != 0); vretrace = vr;
    if (kind != 1) model_write(a, d);
    else rq.push_back(model_read(a));
    if (vr) m_rf = 1'b1;
    @(negedge clock);
    bus.port_w = 1'b0; bus.port_r = 1'b0; vretrace = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_vr();
    @(negedge clock); vretrace = 1'b1; m_rf = 1'b1;
    @(negedge clock); vretrace = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clock); reset = 1'b1; model_reset();
    @(negedge clock); reset = 1'b0;
  endtask

  // Monitor: compares read data and palette writes as the DUT presents them.
  always @(posedge clock) begin : mon
    logic rd_s;
    rd_s = bus.port_r && !bus.port_w && !reset;
    #1;
    if (rd_s) begin
      if (rq.size() == 0) begin
        n_chk++;
        $display("FAIL read_unexpected: got 0x%0h, expected no read", bus.port_o);
      end else check("port_o", 32'(bus.port_o), 32'(rq.pop_front()));
    end
    if (dac_we === 1'b1) begin
      if (dq.size() == 0) begin
        n_chk++;
        $display("FAIL dac_we_unexpected: got wa=0x%0h wd=0x%0h, expected no write", dac_wa, dac_wd);
      end else check("dac_write", 32'({dac_wa, dac_wd}), 32'(dq.pop_front()));
    end
  end

  initial begin
    logic [15:0] a;
    logic [7:0]  d;
    int          r, kind;
    bus.port_a = 0; bus.port_i = 0; bus.port_w = 0; bus.port_r = 0; vretrace = 0;
    for (int i = 0; i < 256; i++) begin
      pal[i] = 12'($urandom);
      m_pal[i] = pal[i];
    end
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_port_o", 32'(bus.port_o), 32'h00);
    check("rst_dac_we", 32'(dac_we), 32'h0);
    check("rst_dac_wa", 32'(dac_wa), 32'h00);
    check("rst_dac_wd", 32'(dac_wd), 32'h000);
    check("rst_dac_ra", 32'(dac_ra), 32'h00);
    check("rst_mode", 32'({page, videomode}), 32'h0);
    check("rst_cursor", 32'(cursor), 32'h000);
    reset = 1'b0;

    access(1, 16'h03D8, 0, 0);
    access(1, 16'h0100, 0, 0);

    access(0, 16'h03C8, 8'h10, 0);
    access(0, 16'h03C9, 8'h3F, 0);
    access(0, 16'h03C9, 8'h20, 0);
    access(0, 16'h03C9, 8'h04, 0);
    check("dac_wd_f81", 32'(dac_wd), 32'hF81);
    access(1, 16'h03C8, 0, 0);

    access(0, 16'h03C8, 8'hFF, 0);
    for (int i = 0; i < 6; i++) access(0, 16'h03C9, 8'($urandom), 0);
    check("wrap_wa", 32'(dac_wa), 32'h00);
    access(0, 16'h03C9, 8'h11, 0);
    access(0, 16'h03C9, 8'h22, 0);
    access(0, 16'h03C8, 8'h05, 0);
    for (int i = 0; i < 3; i++) access(0, 16'h03C9, 8'($urandom), 0);
    check("partial_wa", 32'(dac_wa), 32'h05);

    @(negedge clock); pal[8'h20] = 12'hA5C; m_pal[8'h20] = 12'hA5C;
    access(0, 16'h03C7, 8'h20, 0);
    for (int i = 0; i < 3; i++) access(1, 16'h03C9, 0, 0);
    check("dac_ra_next", 32'(dac_ra), 32'h21);
    access(1, 16'h03C7, 0, 0);

    access(0, 16'h03D4, 8'h0E, 0);
    access(0, 16'h03D5, 8'h07, 0);
    access(0, 16'h03D4, 8'h0F, 0);
    access(0, 16'h03D5, 8'hCF, 0);
    check("cursor_7cf", 32'(cursor), 32'h7CF);
    access(1, 16'h03D5, 0, 0);
    access(0, 16'h03D8, 8'h03, 0);
    check("mode_11", 32'({page, videomode}), 32'h3);

    pulse_vr();
    access(1, 16'h03DA, 0, 0);
    access(1, 16'h03DA, 0, 0);
    access(1, 16'h03DA, 0, 1);
    access(1, 16'h03DA, 0, 0);

    access(0, 16'h03C8, 8'h30, 0);
    access(0, 16'h03C9, 8'h3C, 0);
    access(0, 16'h03C9, 8'h18, 0);
    pulse_reset();
    access(0, 16'h03C9, 8'h08, 0);
    access(0, 16'h03C9, 8'h2C, 0);
    access(0, 16'h03C9, 8'h34, 0);
    check("post_reset_wa", 32'(dac_wa), 32'h00);

    access(2, 16'h03D8, 8'h01, 0);
    access(1, 16'h03D8, 0, 0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 8))
        0: a = 16'h03C7;
        1: a = 16'h03C8;
        2, 3: a = 16'h03C9;
        4: a = 16'h03D4;
        5: a = 16'h03D5;
        6: a = 16'h03D8;
        7: a = 16'h03DA;
        default: a = 16'($urandom);
      endcase
      d = 8'($urandom);
      if (a == 16'h03D4 && $urandom_range(0, 3) != 0) d = ($urandom_range(0, 1) == 1) ? 8'h0E : 8'h0F;
      r = $urandom_range(0, 99);
      kind = (r < 45) ? 0 : (r < 95) ? 1 : 2;
      access(kind, a, d, $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) pulse_vr();
    end

    repeat (4) @(negedge clock);
    check("end_cursor", 32'(cursor), 32'(m_cursor));
    check("end_mode", 32'({page, videomode}), 32'(m_mode));
    check("end_dac_ra", 32'(dac_ra), 32'(m_rd_idx));
    check("pending_dac_writes", 32'(dq.size()), 32'd0);
    check("pending_reads", 32'(rq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
